// File: rtl/muldiv_div_ctrl.sv
// Divide/remainder sequencer between the issue stage and an iterative divider.
// Latches one operation, waits for the divider (or a watchdog), holds the result.
module muldiv_div_ctrl #(
  parameter int WDOG_LIMIT = 100
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [1:0]   req_op,
  input  logic         req_w,
  input  logic [63:0]  req_a,
  input  logic [63:0]  req_b,
  input  logic         flush,
  output logic         resp_valid,
  input  logic         resp_ready,
  output logic [63:0]  resp_data,
  output logic         resp_err,
  output logic         busy,
  output logic         div_valid,
  output logic [63:0]  div_a,
  output logic [63:0]  div_b,
  output logic         div_uors,
  output logic         div_w,
  input  logic         div_ok,
  input  logic [127:0] div_c
);

  localparam int CW = $clog2(WDOG_LIMIT + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [1:0]    r_op;
  logic          r_w;
  logic [63:0]   r_a;
  logic [63:0]   r_b;
  logic [CW-1:0] r_cnt;
  logic [63:0]   r_data;
  logic          r_err;

  logic          w_accept;
  logic          w_capture;
  logic          w_timeout;
  logic          w_wdog_hit;
  logic [63:0]   w_field;
  logic [63:0]   w_res;

  // op[1] selects remainder, op[0] selects unsigned
  assign w_field = r_op[1] ? div_c[127:64] : div_c[63:0];
  assign w_res = r_w ? {{32{w_field[31]}}, w_field[31:0]} : w_field;
  assign w_wdog_hit = (r_cnt == CW'(WDOG_LIMIT - 1));

  assign div_a     = r_a;
  assign div_b     = r_b;
  assign div_w     = r_w;
  assign resp_data = r_data;
  assign resp_err  = r_err;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next     = r_state;
    req_ready  = 1'b0;
    div_valid  = 1'b0;
    div_uors   = 1'b0;
    resp_valid = 1'b0;
    busy       = 1'b0;
    w_accept   = 1'b0;
    w_capture  = 1'b0;
    w_timeout  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid && !flush) begin
          w_accept = 1'b1;
          w_next   = S_RUN;
        end
      end
      S_RUN: begin
        busy = 1'b1;
        // a kill wins over a completing divider
        if (flush) begin
          w_next = S_IDLE;
        end else begin
          div_valid = 1'b1;
          div_uors  = ~r_op[0];
          if (div_ok) begin
            w_capture = 1'b1;
            w_next    = S_DONE;
          end else if (w_wdog_hit) begin
            w_timeout = 1'b1;
            w_next    = S_DONE;
          end
        end
      end
      S_DONE: begin
        busy = 1'b1;
        if (flush) begin
          w_next = S_IDLE;
        end else begin
          resp_valid = 1'b1;
          if (resp_ready) begin
            w_next = S_IDLE;
          end
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_op   <= 2'd0;
      r_w    <= 1'b0;
      r_a    <= 64'd0;
      r_b    <= 64'd0;
      r_cnt  <= '0;
      r_data <= 64'd0;
      r_err  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_op  <= req_op;
        r_w   <= req_w;
        r_a   <= req_a;
        r_b   <= req_b;
        r_cnt <= '0;
        r_err <= 1'b0;
      end else if (r_state == S_RUN) begin
        r_cnt <= r_cnt + CW'(1);
      end
      if (w_capture) begin
        r_data <= w_res;
        r_err  <= 1'b0;
      end else if (w_timeout) begin
        r_data <= 64'd0;
        r_err  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_div_ctrl.sv
// Directed bench for muldiv_div_ctrl: vector table plus flush,
// watchdog and reset corner sequences, with the bench acting as the divider.
module tb_muldiv_div_ctrl;

  localparam int WDOG = 20;

  logic         clk;
  logic         reset;
  logic         req_valid;
  logic         req_ready;
  logic [1:0]   req_op;
  logic         req_w;
  logic [63:0]  req_a;
  logic [63:0]  req_b;
  logic         flush;
  logic         resp_valid;
  logic         resp_ready;
  logic [63:0]  resp_data;
  logic         resp_err;
  logic         busy;
  logic         div_valid;
  logic [63:0]  div_a;
  logic [63:0]  div_b;
  logic         div_uors;
  logic         div_w;
  logic         div_ok;
  logic [127:0] div_c;

  muldiv_div_ctrl #(.WDOG_LIMIT(WDOG)) dut (
    .clk(clk),
    .reset(reset),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_op(req_op),
    .req_w(req_w),
    .req_a(req_a),
    .req_b(req_b),
    .flush(flush),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_data(resp_data),
    .resp_err(resp_err),
    .busy(busy),
    .div_valid(div_valid),
    .div_a(div_a),
    .div_b(div_b),
    .div_uors(div_uors),
    .div_w(div_w),
    .div_ok(div_ok),
    .div_c(div_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]   op;
    logic         w;
    logic [63:0]  a;
    logic [63:0]  b;
    logic [127:0] c;
    logic [63:0]  exp;
    int           lat;
    int           hold;
  } vec_t;

  vec_t vecs[7];
  int n_total;
  int n_pass;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic issue(input logic [1:0] op, input logic w,
                       input logic [63:0] a, input logic [63:0] b);
    @(negedge clk);
    chk("idle_ready", {63'd0, req_ready}, 64'd1);
    req_valid = 1'b1;
    req_op = op;
    req_w = w;
    req_a = a;
    req_b = b;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    logic [63:0] first;
    issue(v.op, v.w, v.a, v.b);
    chk("run_busy", {63'd0, busy}, 64'd1);
    chk("run_ready", {63'd0, req_ready}, 64'd0);
    chk("run_div_a", div_a, v.a);
    chk("run_div_b", div_b, v.b);
    chk("run_div_w", {63'd0, div_w}, {63'd0, v.w});
    chk("run_uors", {63'd0, div_uors}, {63'd0, ~v.op[0]});
    for (int i = 1; i < v.lat; i++) begin
      @(negedge clk);
      chk("run_div_valid", {63'd0, div_valid}, 64'd1);
      chk("run_no_resp", {63'd0, resp_valid}, 64'd0);
    end
    div_ok = 1'b1;
    div_c = v.c;
    #1;
    chk("ok_cycle_no_resp", {63'd0, resp_valid}, 64'd0);
    @(negedge clk);
    div_ok = 1'b0;
    div_c = 128'd0;
    chk("resp_valid", {63'd0, resp_valid}, 64'd1);
    chk("resp_data", resp_data, v.exp);
    chk("resp_err", {63'd0, resp_err}, 64'd0);
    chk("done_div_valid", {63'd0, div_valid}, 64'd0);
    first = resp_data;
    for (int h = 0; h < v.hold; h++) begin
      @(negedge clk);
      chk("hold_valid", {63'd0, resp_valid}, 64'd1);
      chk("hold_data", resp_data, v.exp);
    end
    chk("hold_stable", resp_data, first);
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    chk("back_idle_valid", {63'd0, resp_valid}, 64'd0);
    chk("back_idle_ready", {63'd0, req_ready}, 64'd1);
    chk("back_idle_busy", {63'd0, busy}, 64'd0);
  endtask

  initial begin
    n_total = 0;
    n_pass = 0;
    reset = 1'b1;
    req_valid = 1'b0;
    req_op = 2'd0;
    req_w = 1'b0;
    req_a = 64'd0;
    req_b = 64'd0;
    flush = 1'b0;
    resp_ready = 1'b0;
    div_ok = 1'b0;
    div_c = 128'd0;

    // DIVU 100/7
    vecs[0] = '{2'd1, 1'b0, 64'd100, 64'd7,
                {64'd2, 64'd14}, 64'd14, 3, 5};
    // REM -7 % 2 -> -1
    vecs[1] = '{2'd2, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2,
                {64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFD},
                64'hFFFF_FFFF_FFFF_FFFF, 1, 0};
    // DIVW 0x80000000 / 0 -> all ones
    vecs[2] = '{2'd0, 1'b1, 64'h0000_0000_8000_0000, 64'd0,
                {64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF},
                64'hFFFF_FFFF_FFFF_FFFF, 4, 1};
    // REMW 0x80000000 % 0 -> sign-extended dividend
    vecs[3] = '{2'd2, 1'b1, 64'h0000_0000_8000_0000, 64'd0,
                {64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF},
                64'hFFFF_FFFF_8000_0000, 2, 2};
    // DIVUW 0xFFFFFFFE / 1 -> sign-extended
    vecs[4] = '{2'd1, 1'b1, 64'h1234_5678_FFFF_FFFE, 64'd1,
                {64'd0, 64'h0000_0000_FFFF_FFFE},
                64'hFFFF_FFFF_FFFF_FFFE, 2, 0};
    // REMU 100 % 7
    vecs[5] = '{2'd3, 1'b0, 64'd100, 64'd7,
                {64'd2, 64'd14}, 64'd2, 5, 1};
    // DIV -20 / 3 -> -6
    vecs[6] = '{2'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3,
                {64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFA},
                64'hFFFF_FFFF_FFFF_FFFA, 2, 0};

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", {63'd0, req_ready}, 64'd1);
    chk("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
    chk("rst_resp_data", resp_data, 64'd0);
    chk("rst_resp_err", {63'd0, resp_err}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_div_valid", {63'd0, div_valid}, 64'd0);
    chk("rst_div_a", div_a, 64'd0);
    chk("rst_div_b", div_b, 64'd0);
    chk("rst_div_uors", {63'd0, div_uors}, 64'd0);
    chk("rst_div_w", {63'd0, div_w}, 64'd0);
    reset = 1'b0;

    for (int k = 0; k < 7; k++) begin
      run_vec(vecs[k]);
    end

    // flush on the 10th RUN cycle
    issue(2'd0, 1'b0, 64'd50, 64'd5);
    for (int i = 1; i < 10; i++) begin
      @(negedge clk);
    end
    chk("pre_flush_div_valid", {63'd0, div_valid}, 64'd1);
    flush = 1'b1;
    #1;
    chk("flush_cycle_div_valid", {63'd0, div_valid}, 64'd0);
    @(negedge clk);
    flush = 1'b0;
    chk("flush_next_div_valid", {63'd0, div_valid}, 64'd0);
    chk("flush_next_ready", {63'd0, req_ready}, 64'd1);
    for (int i = 0; i < WDOG + 2; i++) begin
      @(negedge clk);
      chk("flush_no_resp", {63'd0, resp_valid}, 64'd0);
    end

    // div_ok and flush together: flush wins
    issue(2'd1, 1'b0, 64'd9, 64'd3);
    @(negedge clk);
    div_ok = 1'b1;
    div_c = {64'd0, 64'd3};
    flush = 1'b1;
    @(negedge clk);
    div_ok = 1'b0;
    flush = 1'b0;
    chk("okflush_resp", {63'd0, resp_valid}, 64'd0);
    chk("okflush_ready", {63'd0, req_ready}, 64'd1);
    @(negedge clk);
    chk("okflush_resp2", {63'd0, resp_valid}, 64'd0);

    // request with flush in IDLE is refused
    @(negedge clk);
    req_valid = 1'b1;
    flush = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    flush = 1'b0;
    chk("idle_flush_busy", {63'd0, busy}, 64'd0);
    chk("idle_flush_div_valid", {63'd0, div_valid}, 64'd0);

    // resp_ready in IDLE is ignored
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    chk("idle_rready_resp", {63'd0, resp_valid}, 64'd0);
    chk("idle_rready_ready", {63'd0, req_ready}, 64'd1);

    // flush in DONE drops the response
    issue(2'd3, 1'b0, 64'd10, 64'd4);
    div_ok = 1'b1;
    div_c = {64'd2, 64'd2};
    @(negedge clk);
    div_ok = 1'b0;
    chk("done_before_flush", {63'd0, resp_valid}, 64'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("done_flush_resp", {63'd0, resp_valid}, 64'd0);
    chk("done_flush_busy", {63'd0, busy}, 64'd0);

    // watchdog: no div_ok for WDOG RUN cycles
    issue(2'd0, 1'b0, 64'd1, 64'd1);
    for (int i = 1; i < WDOG; i++) begin
      @(negedge clk);
      chk("wdog_run_no_resp", {63'd0, resp_valid}, 64'd0);
    end
    chk("wdog_last_run_valid", {63'd0, div_valid}, 64'd1);
    @(negedge clk);
    chk("wdog_resp_valid", {63'd0, resp_valid}, 64'd1);
    chk("wdog_resp_err", {63'd0, resp_err}, 64'd1);
    chk("wdog_resp_data", resp_data, 64'd0);
    chk("wdog_div_valid", {63'd0, div_valid}, 64'd0);
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    chk("wdog_back_idle", {63'd0, busy}, 64'd0);

    // a normal op after the watchdog reports no error
    run_vec(vecs[0]);

    // reset mid-RUN
    issue(2'd2, 1'b0, 64'd77, 64'd5);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rstrun_div_valid", {63'd0, div_valid}, 64'd0);
    chk("rstrun_busy", {63'd0, busy}, 64'd0);
    chk("rstrun_div_a", div_a, 64'd0);
    chk("rstrun_resp_data", resp_data, 64'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rstrun_no_resp", {63'd0, resp_valid}, 64'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/muldiv_div_ctrl.md
MULDIV_DIV_CTRL -- requirements
Module: muldiv_div_ctrl

Interface
REQ-001 SHALL have parameter WDOG_LIMIT, default 100, the maximum number of RUN cycles without div_ok before a forced error completion.
REQ-002 SHALL have port clk, input, 1: the single clock, rising-edge.
REQ-003 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-004 SHALL have port req_valid, input, 1: the issue stage presents an operation.
REQ-005 SHALL have port req_ready, output, 1: the controller accepts an operation this cycle.
REQ-006 SHALL have port req_op, input, 2: operation select; 0=DIV, 1=DIVU, 2=REM, 3=REMU.
REQ-007 SHALL have port req_w, input, 1: word operation; 1 means 32-bit.
REQ-008 SHALL have ports req_a and req_b, input, 64 each: dividend and divisor.
REQ-009 SHALL have port flush, input, 1: pipeline kill; abandons any in-flight operation.
REQ-010 SHALL have port resp_valid, output, 1: result available.
REQ-011 SHALL have port resp_ready, input, 1: consumer takes the result.
REQ-012 SHALL have port resp_data, output, 64: final architectural result.
REQ-013 SHALL have port resp_err, output, 1: the watchdog expired; resp_data is 0.
REQ-014 SHALL have port busy, output, 1: state is not IDLE.
REQ-015 SHALL have ports div_valid (1), div_a (64), div_b (64), div_uors (1) and div_w (1), all outputs, driving the divider.
REQ-016 SHALL have ports div_ok (1) and div_c (128), inputs from the divider: div_c = {remainder, quotient}.

Function
REQ-017 SHALL implement three states, IDLE, RUN and DONE, held in a registered state variable.
REQ-018 IDLE: SHALL drive req_ready=1, div_valid=0 and resp_valid=0.
REQ-019 IDLE, on req_valid & ~flush: SHALL latch op, w, a and b, clear the watchdog counter, and go to RUN next cycle.
REQ-020 RUN: SHALL hold div_valid=1 continuously, with div_a, div_b and div_w taken from the latched values, and div_uors=1 for DIV/REM and 0 for DIVU/REMU.
REQ-021 RUN: SHALL drive req_ready=0, and the latched operands SHALL NOT change.
REQ-022 RUN, on div_ok: SHALL register the selected result and go to DONE next cycle; resp_valid rises exactly one cycle after div_ok.
REQ-023 Result select: DIV/DIVU SHALL take div_c[63:0]; REM/REMU SHALL take div_c[127:64].
REQ-024 When w=1, resp_data SHALL be the low 32 bits of the selected field, sign-extended from bit 31, for all four ops.
REQ-025 Divide-by-zero SHALL be passed through unchanged: quotient all ones; remainder equals the dividend, sign-extended from bit 31 when w=1.
REQ-026 RUN: the watchdog counter SHALL increment each cycle; on reaching WDOG_LIMIT without div_ok, the block SHALL go to DONE with resp_err=1 and resp_data=0.
REQ-027 DONE: SHALL hold resp_valid=1 with resp_data and resp_err stable until resp_ready=1, then go to IDLE.
REQ-028 DONE: SHALL drive div_valid=0, so the divider always sees at least one valid-low cycle between operations.
REQ-029 A flush in RUN or DONE SHALL return the block to IDLE next cycle and drop div_valid that cycle; no response is produced.
REQ-030 div_ok and flush asserted in the same RUN cycle: flush SHALL win and the result is discarded.
REQ-031 A flush asserted in IDLE together with req_valid: the request SHALL NOT be accepted.
REQ-032 resp_ready while resp_valid=0 SHALL be ignored.
REQ-033 busy SHALL be 1 in RUN and DONE.

Reset
REQ-034 On reset, state SHALL become IDLE and all outputs SHALL read 0 except req_ready=1.
REQ-035 On reset, the latched operands, the result register and the watchdog counter SHALL be cleared.
REQ-036 Reset mid-RUN SHALL drop div_valid on the next cycle and SHALL produce no response.

Verification
REQ-037 DIVU, a=100, b=7, w=0, with a divider model: response must be resp_data=14 one cycle after div_ok, and resp_valid must be held until resp_ready.
REQ-038 REM, a=-7, b=2, w=0: response must be resp_data=0xFFFFFFFFFFFFFFFF (-1).
REQ-039 DIV, w=1, a=0x80000000, b=0: response must be resp_data=0xFFFFFFFFFFFFFFFF; REMW with the same operands must give 0xFFFFFFFF80000000.
REQ-040 Flush on the 10th RUN cycle: div_valid must be 0 on the next cycle, no resp_valid may occur, and req_ready must be 1.
REQ-041 resp_ready held 0 for 5 cycles in DONE: resp_data must stay stable, then the block must return to IDLE the cycle after resp_ready=1.
REQ-042 div_ok never asserted: at the WDOG_LIMIT-th RUN cycle, the block must go to DONE with resp_err=1 and resp_data=0.
